// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encodings for the UART transceiver.
package uart_pkg;
  localparam int CLKS_PER_BIT_DFLT = 434;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a 2-flop input synchroniser; data_o holds the last well-framed byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e            st_q;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rx_s;
  assign rx_s   = sync_q[1];
  assign data_o = data_q;
  // Synchroniser resets to the idle level so release never looks like a start bit.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q   <= RX_IDLE;
      sync_q <= 2'b11;
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      data_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      case (st_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) st_q <= RX_START;
        end
        RX_START:
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            st_q  <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt_q <= cnt_q + 1'b1;
        RX_DATA:
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            sh_q  <= {rx_s, sh_q[DATA_BITS-1:1]};
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) st_q <= RX_STOP;
          end else cnt_q <= cnt_q + 1'b1;
        RX_STOP:
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            st_q  <= RX_IDLE;
            if (rx_s) data_q <= sh_q;
          end else cnt_q <= cnt_q + 1'b1;
        default: st_q <= RX_IDLE;
      endcase
    end
endmodule

// File: rtl/uart_module.sv
// uart_module: 8N1 transmitter of an incrementing byte pattern plus an independent 8N1 receiver.
module uart_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic                 clk,
  input  logic                 rxrst,
  input  logic                 txrst,
  input  logic                 Rx,
  output logic                 Tx,
  output logic [DATA_BITS-1:0] tx_data,
  output logic [DATA_BITS-1:0] data
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  tx_state_e            st_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           idx_q;
  logic [2:0]           nxt_idx;
  logic                 tx_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 last;
  assign last    = cnt_q == LAST;
  assign nxt_idx = idx_q + 3'd1;
  assign Tx      = tx_q;
  assign tx_data = tx_data_q;
  // Tx is a flop with async preset, so txrst truncates a frame immediately.
  always_ff @(posedge clk or posedge txrst)
    if (txrst) begin
      st_q      <= TX_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      tx_data_q <= '0;
    end else begin
      cnt_q <= (st_q == TX_IDLE || last) ? '0 : cnt_q + 1'b1;
      case (st_q)
        TX_IDLE: begin
          st_q <= TX_START;
          tx_q <= 1'b0;
        end
        TX_START:
          if (last) begin
            st_q  <= TX_DATA;
            idx_q <= '0;
            tx_q  <= tx_data_q[0];
          end
        TX_DATA:
          if (last) begin
            idx_q <= nxt_idx;
            st_q  <= (idx_q == 3'd7) ? TX_STOP : TX_DATA;
            tx_q  <= (idx_q == 3'd7) ? 1'b1 : tx_data_q[nxt_idx];
          end
        TX_STOP:
          if (last) begin
            st_q      <= TX_GAP;
            tx_data_q <= tx_data_q + 1'b1;
          end
        TX_GAP:
          if (last) begin
            st_q <= TX_START;
            tx_q <= 1'b0;
          end
        default: st_q <= TX_IDLE;
      endcase
    end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst   (rxrst),
    .rx_i  (Rx),
    .data_o(data)
  );
endmodule

// File: tb/tb_uart_module.sv
// tb_uart_module: frame-level reference model checks of TX schedule, loopback, framing, glitch and resets.
module tb_uart_module;
  localparam int CPB = 16;
  localparam int FP = 11 * CPB;
  logic clk = 0, rxrst = 1, txrst = 1, loop_en = 1, rx_drv = 1;
  logic tx, rx;
  logic [7:0] tx_data, data;
  logic [7:0] exp_data;
  int errors = 0, checks = 0, cur = 0;
  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;
  uart_module #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rxrst(rxrst), .txrst(txrst), .Rx(rx), .Tx(tx), .tx_data(tx_data), .data(data)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cur += n;
  endtask
  task automatic goto(input int c);
    if (c > cur) step(c - cur);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drv = 0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      step(CPB);
    end
    rx_drv = stop;
    step(CPB);
    rx_drv = 1;
    step(2 * CPB);
  endtask
  task automatic test_reset;
    step(5);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    step(5);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_end: got %b want 1", tx); end
  endtask
  task automatic test_first_frame;
    @(negedge clk);
    txrst = 0;
    rxrst = 0;
    @(posedge clk);
    #1;
    cur = 0;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL first_start: got %b want 0", tx); end
    for (int i = 0; i < 8; i++) begin
      goto(CPB * (1 + i) + CPB / 2);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL first_bit%0d: got %b want 0", i, tx); end
    end
    goto(9 * CPB);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL first_stop: got %b want 1", tx); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL first_hold: got %h want 00", tx_data); end
    goto(10 * CPB);
    checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL first_incr: got %h want 01", tx_data); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL first_gap: got %b want 1", tx); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL first_rx: got %h want 00", data); end
    exp_data = 8'h00;
  endtask
  task automatic test_loopback;
    for (int f = 1; f <= 300; f++) begin
      logic [7:0] b;
      b = 8'(f);
      goto(f * FP);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL loop_start f=%0d: got %b want 0", f, tx); end
      checks++; if (tx_data !== b) begin errors++; $display("FAIL loop_tx_data f=%0d: got %h want %h", f, tx_data, b); end
      goto(f * FP + 10 * CPB + CPB / 2);
      checks++; if (data !== b) begin errors++; $display("FAIL loop_rx f=%0d: got %h want %h", f, data, b); end
      exp_data = b;
    end
  endtask
  task automatic test_framing;
    loop_en = 0;
    rx_drv = 1;
    step(CPB);
    send_frame(8'hA5, 1'b0);
    checks++; if (data !== exp_data) begin errors++; $display("FAIL framing_hold: got %h want %h", data, exp_data); end
    send_frame(8'h3C, 1'b1);
    exp_data = 8'h3C;
    checks++; if (data !== exp_data) begin errors++; $display("FAIL framing_good: got %h want 3c", data); end
  endtask
  task automatic test_random_frames;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      logic s;
      b = 8'($urandom_range(0, 255));
      s = $urandom_range(0, 3) != 0;
      send_frame(b, s);
      if (s) exp_data = b;
      checks++; if (data !== exp_data) begin errors++; $display("FAIL rand_frame k=%0d b=%h stop=%b: got %h want %h", k, b, s, data, exp_data); end
    end
  endtask
  task automatic test_glitch;
    rx_drv = 0;
    step(CPB / 4);
    rx_drv = 1;
    step(2 * CPB);
    checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_hold: got %h want %h", data, exp_data); end
    send_frame(8'h5A, 1'b1);
    exp_data = 8'h5A;
    checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_recover: got %h want 5a", data); end
  endtask
  task automatic test_rx_midframe;
    rx_drv = 0;
    step(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_drv = ~i[0];
      step(CPB);
    end
    rxrst = 1;
    #1;
    exp_data = 8'h00;
    checks++; if (data !== exp_data) begin errors++; $display("FAIL rxrst_clear: got %h want 00", data); end
    rx_drv = 1;
    step(2);
    rxrst = 0;
    step(2 * CPB);
    checks++; if (data !== exp_data) begin errors++; $display("FAIL rxrst_after: got %h want 00", data); end
    send_frame(8'h81, 1'b1);
    exp_data = 8'h81;
    checks++; if (data !== exp_data) begin errors++; $display("FAIL rxrst_recover: got %h want 81", data); end
  endtask
  task automatic test_tx_midframe;
    int f;
    logic [7:0] b;
    f = cur / FP + 1;
    b = 8'(f);
    while (b == 8'h00 || b[2]) begin
      f++;
      b = 8'(f);
    end
    goto(f * FP + 3 * CPB + CPB / 2);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL txrst_pre_bit: got %b want 0", tx); end
    checks++; if (tx_data !== b) begin errors++; $display("FAIL txrst_pre_data: got %h want %h", tx_data, b); end
    txrst = 1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL txrst_tx: got %b want 1", tx); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL txrst_data: got %h want 00", tx_data); end
    step(3);
    @(negedge clk);
    loop_en = 1;
    txrst = 0;
    @(posedge clk);
    #1;
    cur = 0;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL txrst_restart: got %b want 0", tx); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL txrst_restart_data: got %h want 00", tx_data); end
    goto(10 * CPB + CPB / 2);
    exp_data = 8'h00;
    checks++; if (data !== exp_data) begin errors++; $display("FAIL txrst_loop_rx: got %h want 00", data); end
    checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL txrst_next: got %h want 01", tx_data); end
  endtask
  initial begin
    test_reset;
    test_first_frame;
    test_loopback;
    test_framing;
    test_random_frames;
    test_glitch;
    test_rx_midframe;
    test_tx_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
